instruction_decode_stage: RTL and testbench

//  Pipelined, parametrised MIPS-subset decoder: takes fetched instruction+PC over valid/ready,

---
 rtl/instruction_decode_stage_if.sv | 47 ++++
 rtl/instruction_decode_stage.sv | 236 +++++++++++++++++++++++
 tb/tb_instruction_decode_stage.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_decode_stage_if.sv
// Fetch -> decode -> execute handshake bundle for instruction_decode_stage.
//   in_valid/in_ready/in_instr/in_pc : instruction offered by fetch
//   out_valid/out_ready/out_*        : registered control bundle towards execute
// Modports: slave = decode stage side, master = fetch/execute (environment) side.
interface instruction_decode_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [4:0]      out_rs;
  logic [4:0]      out_rt;
  logic [4:0]      out_wdest;
  logic            out_reg_we;
  logic            out_mem_re;
  logic            out_mem_we;
  logic            out_alu_src_imm;
  logic [1:0]      out_alu_op;
  logic [XLEN-1:0] out_imm_ext;
  logic            out_beq;
  logic            out_bne;
  logic            out_jump;
  logic            out_jump_reg;
  logic            out_link;
  logic [25:0]     out_jtarget;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs, out_rt, out_wdest, out_reg_we, out_mem_re,
           out_mem_we, out_alu_src_imm, out_alu_op, out_imm_ext, out_beq, out_bne, out_jump,
           out_jump_reg, out_link, out_jtarget, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs, out_rt, out_wdest, out_reg_we, out_mem_re,
           out_mem_we, out_alu_src_imm, out_alu_op, out_imm_ext, out_beq, out_bne, out_jump,
           out_jump_reg, out_link, out_jtarget, out_illegal
  );
endinterface

// File: rtl/instruction_decode_stage.sv
// Pipelined MIPS-subset instruction decoder with a one-entry output register.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset (clears bundle, valid, interlock state)
//   flush   : synchronous kill of the held bundle; blocks capture in the same cycle
//   bus     : instruction_decode_stage_if.slave (fetch valid/ready in, control bundle out)
// Optional feature: define DECODE_LOAD_USE_INTERLOCK_EN to stall consumers of a LW result
// for LOAD_USE_BUBBLES cycles; otherwise hazards are left to downstream logic.
module instruction_decode_stage #(
  parameter int unsigned XLEN             = 32,
  parameter int unsigned PC_W             = 32,
  parameter int unsigned LOAD_USE_BUBBLES = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  instruction_decode_stage_if.slave bus
);

  if (XLEN < 16 || LOAD_USE_BUBBLES < 1 || LOAD_USE_BUBBLES > 3) begin : g_bad_params
    $error("instruction_decode_stage: XLEN must be >= 16 and LOAD_USE_BUBBLES in 1..3");
  end

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnJr  = 6'h08;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [1:0] {AluAdd, AluSub, AluSlt, AluXor} alu_op_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      wdest;
    logic            reg_we;
    logic            mem_re;
    logic            mem_we;
    logic            alu_src_imm;
    alu_op_e         alu_op;
    logic [XLEN-1:0] imm_ext;
    logic            beq;
    logic            bne;
    logic            jump;
    logic            jump_reg;
    logic            link;
    logic [25:0]     jtarget;
    logic            illegal;
  } bundle_t;

  bundle_t    bundle_q, bundle_d, dec;
  logic       valid_q, valid_d;
  logic       hazard;
  logic       in_ready;
  logic       fire;
  logic       capture;
  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] in_rs;
  logic [4:0] in_rt;

  assign op    = bus.in_instr[31:26];
  assign funct = bus.in_instr[5:0];
  assign in_rs = bus.in_instr[25:21];
  assign in_rt = bus.in_instr[20:16];

  // Combinational decode of the offered instruction.
  always_comb begin
    dec         = '0;
    dec.pc      = bus.in_pc;
    dec.rs      = in_rs;
    dec.rt      = in_rt;
    dec.wdest   = in_rt;
    dec.imm_ext = XLEN'($signed(bus.in_instr[15:0]));
    dec.jtarget = bus.in_instr[25:0];
    dec.alu_op  = AluAdd;
    case (op)
      OpRtype: begin
        dec.wdest = bus.in_instr[15:11];
        case (funct)
          FnAdd:   dec.reg_we = 1'b1;
          FnSub: begin
            dec.reg_we = 1'b1;
            dec.alu_op = AluSub;
          end
          FnSlt: begin
            dec.reg_we = 1'b1;
            dec.alu_op = AluSlt;
          end
          FnJr:    dec.jump_reg = 1'b1;
          default: dec.illegal  = 1'b1;
        endcase
      end
      OpLw: begin
        dec.reg_we      = 1'b1;
        dec.mem_re      = 1'b1;
        dec.alu_src_imm = 1'b1;
      end
      OpSw: begin
        dec.mem_we      = 1'b1;
        dec.alu_src_imm = 1'b1;
      end
      OpBeq: begin
        dec.beq    = 1'b1;
        dec.alu_op = AluSub;
      end
      OpBne: begin
        dec.bne    = 1'b1;
        dec.alu_op = AluSub;
      end
      OpAddi: begin
        dec.reg_we      = 1'b1;
        dec.alu_src_imm = 1'b1;
      end
      OpXori: begin
        dec.reg_we      = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.alu_op      = AluXor;
        dec.imm_ext     = XLEN'(bus.in_instr[15:0]);
      end
      OpJ:     dec.jump = 1'b1;
      OpJal: begin
        dec.jump   = 1'b1;
        dec.link   = 1'b1;
        dec.reg_we = 1'b1;
        dec.wdest  = 5'd31;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign fire     = valid_q & bus.out_ready;
  assign in_ready = reset_n & ~flush & (~valid_q | bus.out_ready) & ~hazard;
  assign capture  = bus.in_valid & in_ready;

`ifdef DECODE_LOAD_USE_INTERLOCK_EN
  logic [1:0] bub_cnt_q, bub_cnt_d;
  logic [4:0] bub_dest_q, bub_dest_d;
  logic       reads_rs, reads_rt;
  logic       hazard_held, hazard_cnt;

  assign reads_rs = (op != OpJ) && (op != OpJal);
  assign reads_rt = (op == OpRtype) || (op == OpSw) || (op == OpBeq) || (op == OpBne);

  // Held LW still in the output register: its consumer must not enter yet.
  assign hazard_held = valid_q & bundle_q.mem_re & (bundle_q.wdest != 5'd0) &
                       ((reads_rs & (in_rs == bundle_q.wdest)) |
                        (reads_rt & (in_rt == bundle_q.wdest)));
  // LW already handed over: keep blocking its consumers for the remaining bubbles.
  assign hazard_cnt  = (bub_cnt_q != 2'd0) &
                       ((reads_rs & (in_rs == bub_dest_q)) |
                        (reads_rt & (in_rt == bub_dest_q)));
  assign hazard      = hazard_held | hazard_cnt;

  always_comb begin
    bub_cnt_d  = bub_cnt_q;
    bub_dest_d = bub_dest_q;
    if (flush) begin
      bub_cnt_d  = 2'd0;
      bub_dest_d = 5'd0;
    end else if (fire && bundle_q.mem_re && (bundle_q.wdest != 5'd0)) begin
      bub_cnt_d  = 2'(LOAD_USE_BUBBLES - 1);
      bub_dest_d = bundle_q.wdest;
    end else if (bub_cnt_q != 2'd0) begin
      bub_cnt_d  = bub_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bub_cnt_q  <= 2'd0;
      bub_dest_q <= 5'd0;
    end else begin
      bub_cnt_q  <= bub_cnt_d;
      bub_dest_q <= bub_dest_d;
    end
  end
`else
  assign hazard = 1'b0;
`endif

  // Flush beats capture and fire; capture on a firing slot keeps valid high.
  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d  = 1'b1;
      bundle_d = dec;
    end else if (fire) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = valid_q;
  assign bus.out_pc          = bundle_q.pc;
  assign bus.out_rs          = bundle_q.rs;
  assign bus.out_rt          = bundle_q.rt;
  assign bus.out_wdest       = bundle_q.wdest;
  assign bus.out_reg_we      = bundle_q.reg_we;
  assign bus.out_mem_re      = bundle_q.mem_re;
  assign bus.out_mem_we      = bundle_q.mem_we;
  assign bus.out_alu_src_imm = bundle_q.alu_src_imm;
  assign bus.out_alu_op      = bundle_q.alu_op;
  assign bus.out_imm_ext     = bundle_q.imm_ext;
  assign bus.out_beq         = bundle_q.beq;
  assign bus.out_bne         = bundle_q.bne;
  assign bus.out_jump        = bundle_q.jump;
  assign bus.out_jump_reg    = bundle_q.jump_reg;
  assign bus.out_link        = bundle_q.link;
  assign bus.out_jtarget     = bundle_q.jtarget;
  assign bus.out_illegal     = bundle_q.illegal;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Self-checking bench for instruction_decode_stage: table of decode vectors pushed through a
// scoreboard, plus directed sequences for backpressure, flush, load-use and async reset.
module tb_instruction_decode_stage;

  logic clk = 1'b0;
  logic reset_n;
  logic flush;

  always #5 clk = ~clk;

  instruction_decode_stage_if #(.XLEN(32), .PC_W(32)) bus ();

  instruction_decode_stage #(
    .XLEN(32),
    .PC_W(32),
    .LOAD_USE_BUBBLES(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .flush(flush),
    .bus(bus)
  );

  // ctl = {we, mem_re, mem_we, alu_src_imm, alu_op[1:0], beq, bne, jump, jump_reg, link, illegal}
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [11:0] ctl;
    logic [4:0]  wdest;
    logic [31:0] imm;
    bit          full;
  } vec_t;

  vec_t        tbl[15];
  vec_t        exp_q[$];
  vec_t        drv;
  int          n_pass = 0;
  int          n_total = 0;
  bit          last_ov, last_rdy, last_cap;
  logic [31:0] last_pc;

  function automatic vec_t mk(input logic [31:0] instr, input logic [11:0] ctl,
                              input logic [4:0] wd, input logic [31:0] imm, input bit full);
    vec_t v;
    v.instr = instr;
    v.pc    = 32'h0;
    v.ctl   = ctl;
    v.wdest = wd;
    v.imm   = imm;
    v.full  = full;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic compare_out();
    vec_t        e;
    logic [11:0] act_ctl;
    logic [11:0] mask;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_out: got bundle pc 0x%0h, expected no output", bus.out_pc);
      return;
    end
    e = exp_q.pop_front();
    // Illegal/J entries: alu_src_imm and alu_op are not pinned down, so skip them.
    mask = e.full ? 12'hFFF : 12'hE3F;
    act_ctl = {bus.out_reg_we, bus.out_mem_re, bus.out_mem_we, bus.out_alu_src_imm,
               bus.out_alu_op, bus.out_beq, bus.out_bne, bus.out_jump, bus.out_jump_reg,
               bus.out_link, bus.out_illegal};
    check($sformatf("ctl@%0h", e.pc), 64'(act_ctl & mask), 64'(e.ctl & mask));
    check($sformatf("pc@%0h", e.pc), 64'(bus.out_pc), 64'(e.pc));
    check($sformatf("rs@%0h", e.pc), 64'(bus.out_rs), 64'(e.instr[25:21]));
    check($sformatf("rt@%0h", e.pc), 64'(bus.out_rt), 64'(e.instr[20:16]));
    check($sformatf("jtarget@%0h", e.pc), 64'(bus.out_jtarget), 64'(e.instr[25:0]));
    if (e.full) begin
      check($sformatf("wdest@%0h", e.pc), 64'(bus.out_wdest), 64'(e.wdest));
      check($sformatf("imm@%0h", e.pc), 64'(bus.out_imm_ext), 64'(e.imm));
    end
  endtask

  // Called at posedge+1; samples at the following negedge, returns at next posedge+1.
  task automatic step();
    @(negedge clk);
    last_ov  = bus.out_valid;
    last_rdy = bus.in_ready;
    last_pc  = bus.out_pc;
    last_cap = 1'b0;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) compare_out();
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(drv);
        last_cap = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input vec_t v, input logic [31:0] pc);
    drv          = v;
    drv.pc       = pc;
    bus.in_instr = v.instr;
    bus.in_pc    = pc;
    bus.in_valid = 1'b1;
  endtask

  task automatic check_all_zero(input string name);
    logic any;
    any = |{bus.out_valid, bus.out_pc, bus.out_rs, bus.out_rt, bus.out_wdest, bus.out_reg_we,
            bus.out_mem_re, bus.out_mem_we, bus.out_alu_src_imm, bus.out_alu_op,
            bus.out_imm_ext, bus.out_beq, bus.out_bne, bus.out_jump, bus.out_jump_reg,
            bus.out_link, bus.out_jtarget, bus.out_illegal};
    check({name, "_outs"}, 64'(any), 64'd0);
    check({name, "_in_ready"}, 64'(bus.in_ready), 64'd0);
  endtask

  // LW then consumer back-to-back; counts out_valid=0 cycles between their outputs.
  task automatic lw_then(input vec_t consumer, input logic [31:0] base,
                         output int gap, output bit ok);
    bit seen;
    seen = 1'b0;
    gap  = 0;
    ok   = 1'b0;
    bus.out_ready = 1'b1;
    offer(tbl[4], base);
    step();
    offer(consumer, base + 32'd4);
    for (int k = 0; k < 10; k++) begin
      step();
      if (last_cap) bus.in_valid = 1'b0;
      if (last_ov && last_pc == base + 32'd4) begin
        ok = 1'b1;
        break;
      end
      if (seen && !last_ov) gap++;
      if (last_ov && last_pc == base) seen = 1'b1;
    end
    bus.in_valid = 1'b0;
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t add_dep, add_ind;
    int   gap;
    bit   ok;
    int   exp_gap;

    reset_n      = 1'b0;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = 32'h0;
    bus.in_pc    = 32'h0;
    bus.out_ready = 1'b0;

    tbl[0]  = mk(32'h012A4020, 12'b1000_0000_0000, 5'd8,  32'h00004020, 1'b1); // add $8,$9,$10
    tbl[1]  = mk(32'h00221822, 12'b1000_0100_0000, 5'd3,  32'h00001822, 1'b1); // sub $3,$1,$2
    tbl[2]  = mk(32'h00C7282A, 12'b1000_1000_0000, 5'd5,  32'h0000282A, 1'b1); // slt $5,$6,$7
    tbl[3]  = mk(32'h03E00008, 12'b0000_0000_0100, 5'd0,  32'h00000008, 1'b1); // jr $31
    tbl[4]  = mk(32'h8D280000, 12'b1101_0000_0000, 5'd8,  32'h00000000, 1'b1); // lw $8,0($9)
    tbl[5]  = mk(32'hAFA4FFFC, 12'b0011_0000_0000, 5'd4,  32'hFFFFFFFC, 1'b1); // sw $4,-4($29)
    tbl[6]  = mk(32'h10220010, 12'b0000_0110_0000, 5'd2,  32'h00000010, 1'b1); // beq $1,$2
    tbl[7]  = mk(32'h1464FFFF, 12'b0000_0101_0000, 5'd4,  32'hFFFFFFFF, 1'b1); // bne $3,$4
    tbl[8]  = mk(32'h2041FFFF, 12'b1001_0000_0000, 5'd1,  32'hFFFFFFFF, 1'b1); // addi 0xFFFF
    tbl[9]  = mk(32'h3841FFFF, 12'b1001_1100_0000, 5'd1,  32'h0000FFFF, 1'b1); // xori 0xFFFF
    tbl[10] = mk(32'h08123456, 12'b0000_0000_1000, 5'd0,  32'h0,        1'b0); // j
    tbl[11] = mk(32'h0C000010, 12'b1000_0000_1010, 5'd31, 32'h00000010, 1'b1); // jal
    tbl[12] = mk(32'hFC000000, 12'b0000_0000_0001, 5'd0,  32'h0,        1'b0); // opcode 0x3F
    tbl[13] = mk(32'h0000003F, 12'b0000_0000_0001, 5'd0,  32'h0,        1'b0); // funct 0x3F
    tbl[14] = mk(32'h00220020, 12'b1000_0000_0000, 5'd0,  32'h00000020, 1'b1); // add $0,$1,$2
    add_dep = mk(32'h01031020, 12'b1000_0000_0000, 5'd2,  32'h00001020, 1'b1); // add $2,$8,$3
    add_ind = mk(32'h00831020, 12'b1000_0000_0000, 5'd2,  32'h00001020, 1'b1); // add $2,$4,$3

    #2;
    check_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Decode table, one instruction per cycle at full throughput.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      offer(tbl[i], 32'h1000 + 32'(4 * i));
      step();
      check($sformatf("tbl_in_ready[%0d]", i), 64'(last_rdy), 64'd1);
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("drain_sb_empty", 64'(exp_q.size()), 64'd0);
    check("drain_out_valid", 64'(last_ov), 64'd0);

    // Backpressure: bundle held for 3 cycles, then exactly one fire.
    bus.out_ready = 1'b0;
    offer(tbl[0], 32'h2000);
    step();
    check("stall_cap", 64'(last_cap), 64'd1);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_out_valid", 64'(last_ov), 64'd1);
      check("stall_in_ready", 64'(last_rdy), 64'd0);
      check("stall_pc", 64'(last_pc), 64'h2000);
    end
    bus.out_ready = 1'b1;
    step();
    step();
    check("stall_single_fire", 64'(last_ov), 64'd0);

    // Flush with a held bundle and a new instruction offered.
    bus.out_ready = 1'b0;
    offer(tbl[1], 32'h3000);
    step();
    flush = 1'b1;
    offer(tbl[9], 32'h3004);
    bus.out_ready = 1'b1;
    step();
    check("flush_in_ready", 64'(last_rdy), 64'd0);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    step();
    check("flush_out_valid", 64'(last_ov), 64'd0);

    // Load-use: dependent consumer vs independent consumer.
`ifdef DECODE_LOAD_USE_INTERLOCK_EN
    exp_gap = 1;
`else
    exp_gap = 0;
`endif
    lw_then(add_dep, 32'h4000, gap, ok);
    check("lu_dep_arrived", 64'(ok), 64'd1);
    check("lu_dep_gap", 64'(gap), 64'(exp_gap));
    lw_then(add_ind, 32'h4100, gap, ok);
    check("lu_ind_arrived", 64'(ok), 64'd1);
    check("lu_ind_gap", 64'(gap), 64'd0);

    // Asynchronous reset mid-stream with a valid held bundle.
    bus.out_ready = 1'b0;
    offer(tbl[8], 32'h5000);
    step();
    bus.in_valid = 1'b0;
    check("prerst_out_valid", 64'(bus.out_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    check("postrst_out_valid", 64'(last_ov), 64'd0);
    check("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
